serial_twos_comp_n: RTL and testbench

//  Parametrised bit-serial two's-complement unit. LANES independent serial lanes share one framing and mode.

---
 rtl/serial_twos_comp_n.sv | 253 +++++++++++++++++++++++++
 tb/tb_serial_twos_comp_n.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp_n.sv
// serial_twos_comp_n
// Bit-serial two's-complement unit. LANES serial lanes share one word framing
// and one mode. Each WIDTH-bit word (LSB first) is captured whole, then
// re-emitted in WIDTH contiguous cycles as pass-through, negated or
// absolute-valued. A per-lane overflow flag marks a negated most-negative
// word. Latency is the same in every mode.

module serial_twos_comp_n #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [LANES-1:0] in_bit,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eow,
  output logic [LANES-1:0] out_bit,
  output logic [LANES-1:0] ovf,
  output logic             sof_err
);

  localparam int                CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     ZERO_IDX  = {CW{1'b0}};
  localparam logic [CW-1:0]     ONE_IDX   = CW'(1'b1);
  localparam logic [CW-1:0]     LAST_IDX  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_WORD  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0]        MODE_NEG  = 2'b01;
  localparam logic [1:0]        MODE_ABS  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Capture side
  logic [CW-1:0]                     cnt_r;
  logic [1:0]                        mode_r;
  logic [LANES-1:0][WIDTH-2:0]       cap_r;
  logic                              sof_err_r;
  logic [CW-1:0]                     pos_s;
  logic                              resync_s;
  logic                              done_s;
  logic [LANES-1:0][WIDTH-1:0]       word_s;

  // Output FSM
  state_t                            state_r;
  state_t                            state_nxt_s;
  logic [CW-1:0]                     ocnt_r;
  logic [CW-1:0]                     ocnt_nxt_s;
  logic                              load_s;
  logic [CW-1:0]                     nidx_s;

  // Emit datapath: sh_r holds the bits still to be sent (bit 0 next)
  logic [LANES-1:0][WIDTH-2:0]       sh_r;
  logic [LANES-1:0][WIDTH-2:0]       sh_d_s;
  logic [LANES-1:0]                  neg_r;
  logic [LANES-1:0]                  neg_d_s;
  logic [LANES-1:0]                  seen_r;
  logic [LANES-1:0]                  seen_d_s;
  logic [LANES-1:0]                  pend_r;
  logic [LANES-1:0]                  pend_d_s;

  // Registered outputs
  logic                              out_valid_r;
  logic                              out_sof_r;
  logic                              out_eow_r;
  logic [LANES-1:0]                  out_bit_r;
  logic [LANES-1:0]                  ovf_r;
  logic                              out_valid_d_s;
  logic                              out_sof_d_s;
  logic                              out_eow_d_s;
  logic [LANES-1:0]                  out_bit_d_s;
  logic [LANES-1:0]                  ovf_d_s;

  // Capture control: an accepted in_sof always restarts the word at bit 0
  always_comb begin
    resync_s = in_valid & in_sof & (cnt_r != ZERO_IDX);
    if (in_valid && in_sof) begin
      pos_s = ZERO_IDX;
    end else begin
      pos_s = cnt_r;
    end
    done_s = in_valid & (pos_s == LAST_IDX);
  end

  // Full word per lane: the MSB comes straight from the bit being accepted
  always_comb begin
    word_s = {(LANES*WIDTH){1'b0}};
    for (int l = 0; l < LANES; l++) begin
      word_s[l] = {in_bit[l], cap_r[l]};
    end
  end

  // Bit counter, mode latch on bit 0, and resync error pulse
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      cnt_r     <= ZERO_IDX;
      mode_r    <= 2'b00;
      sof_err_r <= 1'b0;
    end else begin
      sof_err_r <= resync_s;
      if (in_valid) begin
        if (done_s) begin
          cnt_r <= ZERO_IDX;
        end else begin
          cnt_r <= pos_s + ONE_IDX;
        end
        if (pos_s == ZERO_IDX) begin
          mode_r <= mode;
        end
      end
    end
  end

  // Capture registers hold bits 0..WIDTH-2 of the word being received
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      cap_r <= {(LANES*(WIDTH-1)){1'b0}};
    end else begin
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (in_valid && (pos_s == CW'(i))) begin
            cap_r[l][i] <= in_bit[l];
          end
        end
      end
    end
  end

  // Output FSM state register
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_r <= ST_IDLE;
      ocnt_r  <= ZERO_IDX;
    end else begin
      state_r <= state_nxt_s;
      ocnt_r  <= ocnt_nxt_s;
    end
  end

  // Output FSM next state: a word completing on the last EMIT edge chains directly
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (done_s) begin
          state_nxt_s = ST_EMIT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (ocnt_r == LAST_IDX) begin
          if (done_s) begin
            state_nxt_s = ST_EMIT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    nidx_s = ocnt_r + ONE_IDX;
    if (load_s) begin
      ocnt_nxt_s = ZERO_IDX;
    end else if (state_r == ST_EMIT) begin
      ocnt_nxt_s = nidx_s;
    end else begin
      ocnt_nxt_s = ZERO_IDX;
    end
  end

  // Output FSM outputs: next values of the emit datapath and output registers
  always_comb begin
    out_valid_d_s = 1'b0;
    out_sof_d_s   = 1'b0;
    out_eow_d_s   = 1'b0;
    out_bit_d_s   = {LANES{1'b0}};
    ovf_d_s       = {LANES{1'b0}};
    sh_d_s        = sh_r;
    neg_d_s       = neg_r;
    seen_d_s      = seen_r;
    pend_d_s      = pend_r;
    if (load_s) begin
      out_valid_d_s = 1'b1;
      out_sof_d_s   = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        neg_d_s[l]     = (mode_r == MODE_NEG) |
                         ((mode_r == MODE_ABS) & word_s[l][WIDTH-1]);
        pend_d_s[l]    = neg_d_s[l] & (word_s[l] == MIN_WORD);
        sh_d_s[l]      = word_s[l][WIDTH-1:1];
        // Bit 0 is never inverted: no earlier one has been seen yet
        out_bit_d_s[l] = word_s[l][0];
        seen_d_s[l]    = word_s[l][0];
      end
    end else if ((state_r == ST_EMIT) && (ocnt_r != LAST_IDX)) begin
      out_valid_d_s = 1'b1;
      out_eow_d_s   = (nidx_s == LAST_IDX);
      for (int l = 0; l < LANES; l++) begin
        out_bit_d_s[l] = sh_r[l][0] ^ (neg_r[l] & seen_r[l]);
        seen_d_s[l]    = seen_r[l] | sh_r[l][0];
        sh_d_s[l]      = sh_r[l] >> 1'b1;
        ovf_d_s[l]     = out_eow_d_s & pend_r[l];
      end
    end else begin
      out_valid_d_s = 1'b0;
    end
  end

  // Emit datapath and output registers
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      sh_r        <= {(LANES*(WIDTH-1)){1'b0}};
      neg_r       <= {LANES{1'b0}};
      seen_r      <= {LANES{1'b0}};
      pend_r      <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eow_r   <= 1'b0;
      out_bit_r   <= {LANES{1'b0}};
      ovf_r       <= {LANES{1'b0}};
    end else begin
      sh_r        <= sh_d_s;
      neg_r       <= neg_d_s;
      seen_r      <= seen_d_s;
      pend_r      <= pend_d_s;
      out_valid_r <= out_valid_d_s;
      out_sof_r   <= out_sof_d_s;
      out_eow_r   <= out_eow_d_s;
      out_bit_r   <= out_bit_d_s;
      ovf_r       <= ovf_d_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sof   = out_sof_r;
  assign out_eow   = out_eow_r;
  assign out_bit   = out_bit_r;
  assign ovf       = ovf_r;
  assign sof_err   = sof_err_r;

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Directed bench for serial_twos_comp_n (WIDTH=8, LANES=2).
// A negedge monitor assembles emitted words; each test task drives words
// and compares the assembled results against hand-computed values.

module tb_serial_twos_comp_n;

  localparam int W = 8;
  localparam int L = 2;

  logic         t_clk = 1'b0;
  logic         r_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [L-1:0] in_bit = 2'b00;
  logic [1:0]   mode = 2'b00;
  logic         out_valid, out_sof, out_eow, sof_err;
  logic [L-1:0] out_bit, ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_cyc = 0;
  int first_cyc = 0;

  logic [7:0] got_w0[$];
  logic [7:0] got_w1[$];
  logic [1:0] got_ovf[$];
  int         got_sofc[$];
  int         got_eowc[$];
  int         got_len[$];
  logic [7:0] cw0 = 8'h00;
  logic [7:0] cw1 = 8'h00;
  int         pos = 0;
  int         sofc = 0;
  int         ovf_bad = 0;
  int         valid_cnt = 0;
  int         serr_cnt = 0;
  int         serr_cyc = 0;

  serial_twos_comp_n #(.WIDTH(W), .LANES(L)) dut (
    .t_clk    (t_clk),
    .r_n      (r_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_bit   (in_bit),
    .mode     (mode),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eow  (out_eow),
    .out_bit  (out_bit),
    .ovf      (ovf),
    .sof_err  (sof_err)
  );

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) cyc <= cyc + 1;

  // Monitor: assemble output words away from the active edge
  always @(negedge t_clk) begin
    if (sof_err === 1'b1) begin
      serr_cnt = serr_cnt + 1;
      serr_cyc = cyc;
    end
    if (ovf !== 2'b00 && out_eow !== 1'b1) ovf_bad = ovf_bad + 1;
    if (out_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      if (out_sof === 1'b1) begin
        pos = 0; cw0 = 8'h00; cw1 = 8'h00; sofc = cyc;
      end
      if (pos < 8) begin
        cw0[pos] = out_bit[0];
        cw1[pos] = out_bit[1];
      end
      pos = pos + 1;
      if (out_eow === 1'b1) begin
        got_w0.push_back(cw0);
        got_w1.push_back(cw1);
        got_ovf.push_back(ovf);
        got_sofc.push_back(sofc);
        got_eowc.push_back(cyc);
        got_len.push_back(pos);
      end
    end
  end

  task automatic drive_bit(input logic b0, input logic b1, input logic sof, input logic [1:0] m);
    @(negedge t_clk);
    in_valid = 1'b1; in_sof = sof; in_bit = {b1, b0}; mode = m;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge t_clk);
      in_valid = 1'b0; in_sof = 1'b0; in_bit = 2'b00;
    end
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] m, input int gap);
    for (int i = 0; i < 8; i++) begin
      drive_bit(w0[i], w1[i], (i == 0), m);
      if (i == 0) first_cyc = last_cyc;
      if (gap > 0 && i < 7) idle(gap);
    end
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (got_w0.size() < n && t < 200) begin
      @(negedge t_clk);
      t++;
    end
    vectors++;
    if (got_w0.size() < n) begin
      miscompares++;
      $display("FAIL wait_words: got %0d words, need %0d", got_w0.size(), n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge t_clk);
    vectors++;
    if ({out_valid, out_sof, out_eow, out_bit, ovf, sof_err} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %b, need 0", {out_valid, out_sof, out_eow, out_bit, ovf, sof_err});
    end
    r_n = 1'b1;
    idle(2);
    vectors++;
    if ({out_valid, out_sof, out_eow, out_bit, ovf, sof_err} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release: outputs %b, need 0", {out_valid, out_sof, out_eow, out_bit, ovf, sof_err});
    end
  endtask

  task automatic test_neg_full;
    int base, lc, s0;
    base = got_w0.size(); s0 = serr_cnt;
    send_word(8'h05, 8'h01, 2'b01, 0);
    lc = last_cyc;
    idle(1);
    wait_words(base + 1);
    if (got_w0.size() > base) begin
      vectors++; if (got_w0[base] !== 8'hFB) begin miscompares++; $display("FAIL neg_lane0: got %h need fb", got_w0[base]); end
      vectors++; if (got_w1[base] !== 8'hFF) begin miscompares++; $display("FAIL neg_lane1: got %h need ff", got_w1[base]); end
      vectors++; if (got_ovf[base] !== 2'b00) begin miscompares++; $display("FAIL neg_ovf: got %b need 00", got_ovf[base]); end
      vectors++; if (got_sofc[base] !== lc + 1) begin miscompares++; $display("FAIL neg_latency: sof at %0d need %0d", got_sofc[base], lc + 1); end
      vectors++; if (got_eowc[base] !== lc + 8) begin miscompares++; $display("FAIL neg_eow: eow at %0d need %0d", got_eowc[base], lc + 8); end
      vectors++; if (got_len[base] !== 8) begin miscompares++; $display("FAIL neg_len: got %0d bits need 8", got_len[base]); end
    end
    vectors++; if (serr_cnt !== s0) begin miscompares++; $display("FAIL neg_no_sof_err: got %0d pulses need 0", serr_cnt - s0); end
  endtask

  task automatic test_back_to_back;
    int base, v0;
    base = got_w0.size(); v0 = valid_cnt;
    send_word(8'hF6, 8'h80, 2'b10, 0);
    send_word(8'h0A, 8'h7F, 2'b10, 0);
    idle(1);
    wait_words(base + 2);
    idle(2);
    if (got_w0.size() > base + 1) begin
      vectors++; if (got_w0[base] !== 8'h0A) begin miscompares++; $display("FAIL abs_f6: got %h need 0a", got_w0[base]); end
      vectors++; if (got_w1[base] !== 8'h80) begin miscompares++; $display("FAIL abs_80: got %h need 80", got_w1[base]); end
      vectors++; if (got_ovf[base] !== 2'b10) begin miscompares++; $display("FAIL abs_ovf1: got %b need 10", got_ovf[base]); end
      vectors++; if (got_w0[base+1] !== 8'h0A) begin miscompares++; $display("FAIL abs_0a: got %h need 0a", got_w0[base+1]); end
      vectors++; if (got_w1[base+1] !== 8'h7F) begin miscompares++; $display("FAIL abs_7f: got %h need 7f", got_w1[base+1]); end
      vectors++; if (got_ovf[base+1] !== 2'b00) begin miscompares++; $display("FAIL abs_ovf2: got %b need 00", got_ovf[base+1]); end
      vectors++; if (got_sofc[base+1] !== got_eowc[base] + 1) begin miscompares++; $display("FAIL b2b_bubble: sof2 at %0d need %0d", got_sofc[base+1], got_eowc[base] + 1); end
    end
    vectors++; if (valid_cnt - v0 !== 16) begin miscompares++; $display("FAIL b2b_valid: got %0d cycles need 16", valid_cnt - v0); end
  endtask

  task automatic test_ovf;
    int base;
    base = got_w0.size();
    send_word(8'h80, 8'h00, 2'b01, 0);
    send_word(8'h80, 8'h80, 2'b00, 0);
    send_word(8'h05, 8'h80, 2'b11, 0);
    idle(1);
    wait_words(base + 3);
    if (got_w0.size() > base + 2) begin
      vectors++; if ({got_w0[base], got_w1[base]} !== 16'h8000) begin miscompares++; $display("FAIL neg_min: got %h%h need 8000", got_w0[base], got_w1[base]); end
      vectors++; if (got_ovf[base] !== 2'b01) begin miscompares++; $display("FAIL neg_min_ovf: got %b need 01", got_ovf[base]); end
      vectors++; if ({got_w0[base+1], got_w1[base+1]} !== 16'h8080) begin miscompares++; $display("FAIL pass_min: got %h%h need 8080", got_w0[base+1], got_w1[base+1]); end
      vectors++; if (got_ovf[base+1] !== 2'b00) begin miscompares++; $display("FAIL pass_ovf: got %b need 00", got_ovf[base+1]); end
      vectors++; if ({got_w0[base+2], got_w1[base+2]} !== 16'h0580) begin miscompares++; $display("FAIL rsvd_mode: got %h%h need 0580", got_w0[base+2], got_w1[base+2]); end
      vectors++; if (got_ovf[base+2] !== 2'b00) begin miscompares++; $display("FAIL rsvd_ovf: got %b need 00", got_ovf[base+2]); end
    end
  endtask

  task automatic test_stall;
    int base, lc;
    base = got_w0.size();
    send_word(8'h05, 8'h00, 2'b01, 2);
    lc = last_cyc;
    idle(1);
    wait_words(base + 1);
    if (got_w0.size() > base) begin
      vectors++; if ({got_w0[base], got_w1[base]} !== 16'hFB00) begin miscompares++; $display("FAIL stall_word: got %h%h need fb00", got_w0[base], got_w1[base]); end
      vectors++; if (got_sofc[base] !== lc + 1) begin miscompares++; $display("FAIL stall_latency: sof at %0d need %0d", got_sofc[base], lc + 1); end
      vectors++; if (got_eowc[base] !== lc + 8) begin miscompares++; $display("FAIL stall_contig: eow at %0d need %0d", got_eowc[base], lc + 8); end
    end
  endtask

  task automatic test_resync;
    int base, s0;
    base = got_w0.size(); s0 = serr_cnt;
    drive_bit(1'b1, 1'b1, 1'b1, 2'b01);
    drive_bit(1'b1, 1'b1, 1'b0, 2'b01);
    drive_bit(1'b1, 1'b1, 1'b0, 2'b01);
    send_word(8'h05, 8'h03, 2'b01, 0);
    idle(1);
    wait_words(base + 1);
    idle(3);
    vectors++; if (serr_cnt - s0 !== 1) begin miscompares++; $display("FAIL resync_pulse: got %0d pulses need 1", serr_cnt - s0); end
    vectors++; if (serr_cyc !== first_cyc + 1) begin miscompares++; $display("FAIL resync_when: pulse at %0d need %0d", serr_cyc, first_cyc + 1); end
    vectors++; if (got_w0.size() !== base + 1) begin miscompares++; $display("FAIL resync_count: got %0d words need %0d", got_w0.size(), base + 1); end
    if (got_w0.size() > base) begin
      vectors++; if ({got_w0[base], got_w1[base]} !== 16'hFBFD) begin miscompares++; $display("FAIL resync_word: got %h%h need fbfd", got_w0[base], got_w1[base]); end
    end
  endtask

  task automatic test_reset_mid_emit;
    int base, v0, s0;
    base = got_w0.size();
    send_word(8'h05, 8'h05, 2'b01, 0);
    idle(3);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_emit_active: out_valid %b need 1", out_valid); end
    r_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_sof, out_eow, out_bit, ovf, sof_err} !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_emit_reset: outputs %b need 0", {out_valid, out_sof, out_eow, out_bit, ovf, sof_err});
    end
    idle(2);
    r_n = 1'b1;
    v0 = valid_cnt;
    idle(12);
    vectors++; if (valid_cnt !== v0) begin miscompares++; $display("FAIL mid_emit_resume: got %0d valid cycles need 0", valid_cnt - v0); end
    vectors++; if (got_w0.size() !== base) begin miscompares++; $display("FAIL mid_emit_words: got %0d words need %0d", got_w0.size(), base); end
    // A partial capture is dropped by reset; the next sof is then not an error
    s0 = serr_cnt;
    drive_bit(1'b1, 1'b0, 1'b1, 2'b00);
    drive_bit(1'b1, 1'b0, 1'b0, 2'b00);
    drive_bit(1'b1, 1'b0, 1'b0, 2'b00);
    idle(1);
    r_n = 1'b0;
    idle(2);
    r_n = 1'b1;
    idle(1);
    send_word(8'h05, 8'h00, 2'b01, 0);
    idle(1);
    wait_words(base + 1);
    idle(2);
    vectors++; if (serr_cnt !== s0) begin miscompares++; $display("FAIL partial_drop_err: got %0d pulses need 0", serr_cnt - s0); end
    if (got_w0.size() > base) begin
      vectors++; if ({got_w0[base], got_w1[base]} !== 16'hFB00) begin miscompares++; $display("FAIL partial_drop_word: got %h%h need fb00", got_w0[base], got_w1[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_neg_full();
    test_back_to_back();
    test_ovf();
    test_stall();
    test_resync();
    test_reset_mid_emit();
    vectors++;
    if (ovf_bad !== 0) begin
      miscompares++;
      $display("FAIL ovf_qualified: %0d cycles with ovf outside eow, need 0", ovf_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
